s_term_pipe: RTL and testbench
==============================

# s_term_pipe

Parametrised south-terminal tile with configurable loopback retiming. Each of NUM_CH channels loops its southern input wires back to the north outputs. The loopback path is selected per channel from a frame-loaded configuration word: combinational, 1-stage registered, PIPE_DEPTH-stage registered, or tied off. The tile sits at the bottom edge of a fabric column and also forwards the column's FrameStrobe, FrameData and UserCLK.

## Interface
- MaxFramesPerCol, 20, width of FrameStrobe
- FrameBitsPerRow, 32, width of FrameData; must be ≥ 2*NUM_CH
- NUM_CH, 4, loopback channel count (1..16)
- CH_WIDTH, 8, wires per channel (≥1)
- PIPE_DEPTH, 3, stages used by mode 10 (≥2)
- CFG_FRAME, 0, FrameStrobe index that loads the configuration (< MaxFramesPerCol)

Ports:
- UserCLK  in  1  fabric user clock; all state on rising edge
- UserRSTn  in  1  asynchronous active-low reset
- UserCLKo  out  1  buffered UserCLK
- FrameStrobe  in  MaxFramesPerCol  column frame strobes
- FrameStrobe_O  out  MaxFramesPerCol  buffered FrameStrobe, combinational
- FrameData  in  FrameBitsPerRow  row frame data
- FrameData_O  out  FrameBitsPerRow  buffered FrameData, combinational
- S_END  in  NUM_CH*CH_WIDTH  southern inputs; channel i = bits [i*CH_WIDTH +: CH_WIDTH]
- N_BEG  out  NUM_CH*CH_WIDTH  northern outputs, same channel packing
- cfg_valid  out  1  high once at least one configuration has been captured

## Operation
- Per-channel mode, mode[i] = 2 bits:
  - 00: pass, N_BEG ch i = S_END ch i
  - 01: reg1, N_BEG ch i = S_END ch i delayed 1 cycle
  - 10: regN, delayed PIPE_DEPTH cycles
  - 11: off, N_BEG ch i = 0
- Capture FSM, 2 states: IDLE and ARMED_HIGH. State is held in the edge register stb_q = FrameStrobe[CFG_FRAME] sampled on the previous cycle.
  - Capture fires on any rising UserCLK edge where FrameStrobe[CFG_FRAME]=1 and stb_q=0.
  - On capture, mode[i] <= FrameData[2i+1:2i] for all i, and cfg_valid <= 1.
  - FrameData bits above 2*NUM_CH-1 are ignored.
  - A strobe held high for several cycles captures exactly once, on its first sampled-high cycle. The next capture requires one sampled-low cycle.
- Pipeline registers, per channel, PIPE_DEPTH × CH_WIDTH:
  - Stage 0 loads S_END ch i every cycle when the channel's mode is 01 or 10.
  - Stage k loads stage k-1.
  - Mode 01 reads stage 0; mode 10 reads stage PIPE_DEPTH-1.
  - In modes 00 and 11 all stages of that channel are held at 0.
- Mode change flush: at a capture edge, every channel whose new mode differs from its old mode has all its stages cleared to 0. This takes priority over the shift on that edge. Channels whose mode is unchanged keep shifting uninterrupted.
- The N_BEG output mux uses the current mode register, so the new mode takes effect immediately after the capture edge.
- FrameStrobe_O, FrameData_O and UserCLKo are pure buffers with no registers and are independent of reset.

## Timing
- Reset (UserRSTn=0, asynchronous), with the buffers still live:
  - mode = 00 for all channels; N_BEG = S_END combinationally
  - all pipeline stages = 0
  - stb_q = 0
  - cfg_valid = 0
- Reset release: the first rising edge is normal. If FrameStrobe[CFG_FRAME] is already high, that edge captures because stb_q was reset to 0.
- Reset asserted mid-pipeline: stages clear at once, mode reverts to 00, and N_BEG follows S_END in the same cycle.
- Latency from S_END to N_BEG: 0 cycles in mode 00, 1 cycle in mode 01, PIPE_DEPTH cycles in mode 10. Mode 11 is constant 0.
- After a capture edge that switches a channel into 01 or 10, N_BEG for that channel reads 0 until the pipeline refills. The first valid sample appears 1 cycle (01) or PIPE_DEPTH cycles (10) after the capture edge and is the S_END value sampled on the first edge after capture.
- Switching between 01 and 10 also flushes. No sample from the old mode is ever output in the new mode.
- Capture and shift on the same edge: mode, flush and stb_q all update at that edge. S_END is not sampled into a flushed channel at that edge.
- cfg_valid rises on the first capture edge and stays 1 until reset.

## Test plan
- Reset, then S_END=0xA5A5A5A5 with NUM_CH=4, CH_WIDTH=8 → N_BEG=0xA5A5A5A5 in the same cycle; cfg_valid=0.
- Pulse strobe one cycle with FrameData=0x000000E4 (ch0=00, ch1=01, ch2=10, ch3=11), then drive a counter on every byte → ch0 has 0-cycle lag, ch1 1-cycle lag, ch2 3-cycle lag (first valid at capture+3), ch3 reads 0x00; cfg_valid=1.
- Hold the strobe high for 5 cycles while FrameData changes each cycle → only the first cycle's word is captured. Drop the strobe for 1 cycle, raise it again → a second capture occurs.
- With ch2 in mode 10 and its pipeline full, recapture 0x000000D4 (ch2→01, others unchanged) → ch2 outputs 0 for 1 cycle then 1-cycle-lag data; ch1's stream shows no gap.
- Assert UserRSTn low for 1 cycle mid-stream → N_BEG equals S_END immediately, cfg_valid=0, all stages 0. Release with the strobe already high → capture on the first edge.
- Toggle FrameStrobe[5] and FrameData arbitrarily, including during reset → FrameStrobe_O and FrameData_O mirror them exactly, and no capture occurs on index ≠ CFG_FRAME.

Source files
------------

// File: rtl/s_term_pipe.sv
// s_term_pipe: south-terminal tile of a fabric column.
// Each channel loops S_END back to N_BEG through a frame-configured path:
// combinational, 1-stage, PIPE_DEPTH-stage, or tied off. The column's
// FrameStrobe, FrameData and UserCLK are forwarded as plain buffers.
// Configuration is captured on the rising edge of FrameStrobe[CFG_FRAME].
//
// Handshake: there is no valid/ready pair here. A configuration word is
// offered by holding FrameData while FrameStrobe[CFG_FRAME] is high; it is
// accepted exactly once, on the first rising UserCLK edge that samples the
// strobe high after a sampled-low cycle. cfg_valid reports that at least one
// word has been accepted since reset.
module s_term_pipe #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NUM_CH          = 4,
    parameter int CH_WIDTH        = 8,
    parameter int PIPE_DEPTH      = 3,
    parameter int CFG_FRAME       = 0
) (
    input  logic                         UserCLK,
    input  logic                         UserRSTn,
    output logic                         UserCLKo,
    input  logic [MaxFramesPerCol-1:0]   FrameStrobe,
    output logic [MaxFramesPerCol-1:0]   FrameStrobe_O,
    input  logic [FrameBitsPerRow-1:0]   FrameData,
    output logic [FrameBitsPerRow-1:0]   FrameData_O,
    input  logic [NUM_CH*CH_WIDTH-1:0]   S_END,
    output logic [NUM_CH*CH_WIDTH-1:0]   N_BEG,
    output logic                         cfg_valid
);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_REG1 = 2'b01;
    localparam logic [1:0] MODE_REGN = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // Capture FSM: the state register doubles as the strobe edge detector.
    typedef enum logic {
        IDLE       = 1'b0,
        ARMED_HIGH = 1'b1
    } cap_state_t;

    cap_state_t stb_q;
    cap_state_t stb_d;
    logic       cfg_stb;
    logic       capture;

    // Column pass-through buffers; independent of reset.
    assign UserCLKo      = UserCLK;
    assign FrameStrobe_O = FrameStrobe;
    assign FrameData_O   = FrameData;

    assign cfg_stb = FrameStrobe[CFG_FRAME];

    // Capture FSM state register: remembers whether the strobe was high last cycle.
    always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn) begin
            stb_q <= IDLE;
        end else begin
            stb_q <= stb_d;
        end
    end

    // Capture FSM next state: fire only on the first sampled-high cycle of a strobe.
    always_comb begin
        stb_d   = IDLE;
        capture = 1'b0;
        case (stb_q)
            IDLE: begin
                if (cfg_stb) begin
                    stb_d   = ARMED_HIGH;
                    capture = 1'b1;
                end
            end
            ARMED_HIGH: begin
                if (cfg_stb) begin
                    stb_d = ARMED_HIGH;
                end
            end
            default: stb_d = IDLE;
        endcase
    end

    // Sticky flag: set by the first capture, cleared only by reset.
    always_ff @(posedge UserCLK or negedge UserRSTn) begin
        if (!UserRSTn) begin
            cfg_valid <= 1'b0;
        end else if (capture) begin
            cfg_valid <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]          mode_q;
        logic [1:0]          mode_new;
        logic                flush;
        logic                ch_shift;
        logic [CH_WIDTH-1:0] ch_in;
        logic [CH_WIDTH-1:0] ch_out;
        logic [CH_WIDTH-1:0] stage_q [PIPE_DEPTH];

        assign ch_in    = S_END[i*CH_WIDTH +: CH_WIDTH];
        assign mode_new = FrameData[2*i +: 2];
        // A changed mode discards everything in flight so no old-mode sample leaks out.
        assign flush    = capture && (mode_new != mode_q);
        assign ch_shift = (mode_q == MODE_REG1) || (mode_q == MODE_REGN);

        // Mode register: reloaded from the frame word on every capture edge.
        always_ff @(posedge UserCLK or negedge UserRSTn) begin
            if (!UserRSTn) begin
                mode_q <= MODE_PASS;
            end else if (capture) begin
                mode_q <= mode_new;
            end
        end

        // Delay line: flush beats shift; unregistered modes keep it parked at zero.
        always_ff @(posedge UserCLK or negedge UserRSTn) begin
            if (!UserRSTn) begin
                for (int k = 0; k < PIPE_DEPTH; k++) begin
                    stage_q[k] <= '0;
                end
            end else if (flush || !ch_shift) begin
                for (int k = 0; k < PIPE_DEPTH; k++) begin
                    stage_q[k] <= '0;
                end
            end else begin
                stage_q[0] <= ch_in;
                for (int k = 1; k < PIPE_DEPTH; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end

        // Output mux: follows the live mode register, so a new mode applies right after capture.
        always_comb begin
            ch_out = '0;
            case (mode_q)
                MODE_PASS: ch_out = ch_in;
                MODE_REG1: ch_out = stage_q[0];
                MODE_REGN: ch_out = stage_q[PIPE_DEPTH-1];
                MODE_OFF:  ch_out = '0;
                default:   ch_out = '0;
            endcase
        end

        assign N_BEG[i*CH_WIDTH +: CH_WIDTH] = ch_out;
    end

endmodule

// File: tb/tb_s_term_pipe.sv
// tb_s_term_pipe: directed vector table, hand-written corner sequences and
// randomized traffic for s_term_pipe, checked against a history-based model.
module tb_s_term_pipe;

    localparam int MF = 20;
    localparam int FB = 32;
    localparam int NC = 4;
    localparam int CW = 8;
    localparam int PD = 3;
    localparam int CF = 0;
    localparam int NW = NC * CW;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic [MF-1:0] frame_strobe;
    logic [FB-1:0] frame_data;
    logic [NW-1:0] s_end;
    logic          user_clk_o;
    logic [MF-1:0] frame_strobe_o;
    logic [FB-1:0] frame_data_o;
    logic [NW-1:0] n_beg;
    logic          cfg_valid;

    always #5 clk = ~clk;

    s_term_pipe #(
        .MaxFramesPerCol(MF),
        .FrameBitsPerRow(FB),
        .NUM_CH(NC),
        .CH_WIDTH(CW),
        .PIPE_DEPTH(PD),
        .CFG_FRAME(CF)
    ) dut (
        .UserCLK(clk),
        .UserRSTn(rst_n),
        .UserCLKo(user_clk_o),
        .FrameStrobe(frame_strobe),
        .FrameStrobe_O(frame_strobe_o),
        .FrameData(frame_data),
        .FrameData_O(frame_data_o),
        .S_END(s_end),
        .N_BEG(n_beg),
        .cfg_valid(cfg_valid)
    );

    // ---------------- reference model ----------------
    // Each channel remembers the S_END samples taken since it entered its
    // current mode; a d-cycle path outputs the sample from d edges ago, or 0
    // if fewer than d samples have been collected yet.
    logic [1:0]    m_mode [NC];
    logic          m_cv;
    logic          m_prev;
    logic [CW-1:0] hist [NC][$];

    int n_cmp = 0;
    int n_bad = 0;
    logic [NW-1:0] exp_q [$];

    task automatic model_reset();
        for (int ch = 0; ch < NC; ch++) begin
            m_mode[ch] = 2'b00;
            hist[ch].delete();
        end
        m_cv   = 1'b0;
        m_prev = 1'b0;
    endtask

    task automatic model_edge();
        logic       cap;
        logic [1:0] nm;
        if (!rst_n) return;
        cap = frame_strobe[CF] && !m_prev;
        for (int ch = 0; ch < NC; ch++) begin
            nm = cap ? frame_data[2*ch +: 2] : m_mode[ch];
            if (nm != m_mode[ch]) begin
                hist[ch].delete();
            end else if (nm == 2'b01 || nm == 2'b10) begin
                hist[ch].push_back(s_end[ch*CW +: CW]);
                while (hist[ch].size() > PD) void'(hist[ch].pop_front());
            end else begin
                hist[ch].delete();
            end
            m_mode[ch] = nm;
        end
        if (cap) m_cv = 1'b1;
        m_prev = frame_strobe[CF];
    endtask

    function automatic logic [NW-1:0] model_nbeg();
        logic [NW-1:0] v;
        int n;
        v = '0;
        for (int ch = 0; ch < NC; ch++) begin
            n = hist[ch].size();
            case (m_mode[ch])
                2'b00: v[ch*CW +: CW] = s_end[ch*CW +: CW];
                2'b01: if (n >= 1)  v[ch*CW +: CW] = hist[ch][n-1];
                2'b10: if (n >= PD) v[ch*CW +: CW] = hist[ch][n-PD];
                default: ;
            endcase
        end
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        exp_q.push_back(model_nbeg());
        cmp("n_beg_model", n_beg, exp_q.pop_front());
        cmp("cfg_valid_model", cfg_valid, m_cv);
        cmp("strobe_buf", frame_strobe_o, frame_strobe);
        cmp("data_buf", frame_data_o, frame_data);
        cmp("clk_buf", user_clk_o, clk);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic apply(input logic [NW-1:0] s, input logic [MF-1:0] stb,
                         input logic [FB-1:0] fd, input logic rst);
        s_end        = s;
        frame_strobe = stb;
        frame_data   = fd;
        rst_n        = rst;
        if (!rst) model_reset();
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [MF-1:0] cfg_bit(input logic b);
        logic [MF-1:0] v;
        v = '0;
        v[CF] = b;
        return v;
    endfunction

    typedef struct {
        logic          rst;
        logic [NW-1:0] s;
        logic          stb;
        logic [FB-1:0] fd;
        logic [NW-1:0] exp_n;
        logic          exp_cv;
    } vec_t;

    vec_t          vecs [13];
    logic [FB-1:0] held_fd [5];

    initial begin
        logic [NW-1:0] r;
        logic [MF-1:0] fs;
        logic          rr;

        rst_n = 1'b0;
        s_end = '0;
        frame_strobe = '0;
        frame_data = '0;
        model_reset();

        // rst, s_end, strobe, frame_data, expected n_beg, expected cfg_valid
        vecs[0]  = '{1'b0, 32'hA5A5A5A5, 1'b0, 32'h00000000, 32'hA5A5A5A5, 1'b0};
        vecs[1]  = '{1'b1, 32'hA5A5A5A5, 1'b0, 32'h00000000, 32'hA5A5A5A5, 1'b0};
        vecs[2]  = '{1'b1, 32'h01010101, 1'b1, 32'h000000E4, 32'h01010101, 1'b0};
        vecs[3]  = '{1'b1, 32'h02020202, 1'b0, 32'h00000000, 32'h00000002, 1'b1};
        vecs[4]  = '{1'b1, 32'h03030303, 1'b0, 32'h00000000, 32'h00000203, 1'b1};
        vecs[5]  = '{1'b1, 32'h04040404, 1'b0, 32'h00000000, 32'h00000304, 1'b1};
        vecs[6]  = '{1'b1, 32'h05050505, 1'b0, 32'h00000000, 32'h00020405, 1'b1};
        vecs[7]  = '{1'b1, 32'h06060606, 1'b0, 32'h00000000, 32'h00030506, 1'b1};
        vecs[8]  = '{1'b1, 32'h07070707, 1'b0, 32'h00000000, 32'h00040607, 1'b1};
        vecs[9]  = '{1'b1, 32'h08080808, 1'b1, 32'h5A5A00D4, 32'h00050708, 1'b1};
        vecs[10] = '{1'b1, 32'h09090909, 1'b0, 32'h00000000, 32'h00000809, 1'b1};
        vecs[11] = '{1'b1, 32'h0A0A0A0A, 1'b0, 32'h00000000, 32'h0009090A, 1'b1};
        vecs[12] = '{1'b1, 32'h0B0B0B0B, 1'b0, 32'h00000000, 32'h000A0A0B, 1'b1};

        held_fd = '{32'h000000FF, 32'h00000000, 32'h00000055, 32'h000000AA, 32'h0000001B};

        tick();
        tick();

        // Directed table: reset passthrough, E4 capture with counter stream, D4 recapture.
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].s, cfg_bit(vecs[i].stb), vecs[i].fd, vecs[i].rst);
            cmp($sformatf("vec%0d_n_beg", i), n_beg, vecs[i].exp_n);
            cmp($sformatf("vec%0d_cfg_valid", i), cfg_valid, vecs[i].exp_cv);
            tick();
        end

        // Strobe held 5 cycles: only the first word (all channels off) is taken.
        for (int c = 0; c < 5; c++) begin
            r = $urandom | 32'h01010101;
            apply(r, cfg_bit(1'b1), held_fd[c], 1'b1);
            if (c > 0) cmp("held_off", n_beg, 0);
            tick();
        end
        r = $urandom | 32'h01010101;
        apply(r, cfg_bit(1'b0), 32'h00000000, 1'b1);
        cmp("gap_off", n_beg, 0);
        tick();
        r = $urandom | 32'h01010101;
        apply(r, cfg_bit(1'b1), 32'h00000000, 1'b1);
        cmp("recap_before", n_beg, 0);
        tick();
        r = $urandom;
        apply(r, cfg_bit(1'b1), 32'h000000FF, 1'b1);
        cmp("recap_pass", n_beg, r);
        tick();
        r = $urandom;
        apply(r, cfg_bit(1'b0), 32'h00000000, 1'b1);
        cmp("recap_pass2", n_beg, r);
        tick();

        // Reset mid-stream with registered channels, then release with strobe high.
        apply($urandom, cfg_bit(1'b1), 32'h000000A9, 1'b1);
        tick();
        for (int c = 0; c < 6; c++) begin
            apply($urandom, cfg_bit(1'b0), $urandom, 1'b1);
            tick();
        end
        r = $urandom;
        apply(r, cfg_bit(1'b0), 32'h00000000, 1'b0);
        cmp("rst_pass", n_beg, r);
        cmp("rst_cv", cfg_valid, 0);
        tick();
        r = $urandom;
        apply(r, cfg_bit(1'b1), 32'h000000E4, 1'b0);
        cmp("rst_hold_pass", n_beg, r);
        tick();
        r = $urandom;
        apply(r, cfg_bit(1'b1), 32'h000000E4, 1'b1);
        cmp("rel_pass", n_beg, r);
        cmp("rel_cv", cfg_valid, 0);
        tick();
        r = $urandom | 32'hFF000000;
        apply(r, cfg_bit(1'b1), 32'h000000E4, 1'b1);
        cmp("rel_cap_cv", cfg_valid, 1);
        cmp("rel_cap_ch3_off", n_beg[31:24], 0);
        cmp("rel_cap_ch0_pass", n_beg[7:0], r[7:0]);
        tick();

        // Other strobe bits toggle, config bit stays low: no capture may happen.
        apply($urandom, cfg_bit(1'b0), $urandom, 1'b0);
        tick();
        for (int c = 0; c < 30; c++) begin
            fs = MF'($urandom);
            fs[5] = c[0];
            fs[CF] = 1'b0;
            apply($urandom, fs, $urandom, 1'b1);
            tick();
        end
        cmp("other_idx_cv", cfg_valid, 0);

        // Randomized traffic with occasional captures and resets.
        for (int c = 0; c < 400; c++) begin
            fs = MF'($urandom);
            fs[CF] = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 49) != 0);
            apply($urandom, fs, $urandom, rr);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
